rf_writeback_queue: RTL and testbench

- Writeback-side initiator for the core's 3-port register file (two read ports, one write port).
- Buffers writeback results (ALU results, multi-cycle load data) in a small in-order queue and drains them one per cycle onto the write port (WE3/A3/WD3).
- Forwards the youngest pending value for the two read addresses, so decode sees correct operands before the register file has been updated.
- Sits between the execute/memory result sources and the register file's write port.

---
 rtl/rf_writeback_queue_if.sv | 25 ++
 rtl/rf_writeback_queue.sv | 121 ++++++++++++
 tb/tb_rf_writeback_queue.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/rf_writeback_queue_if.sv
// Writeback request channel into the register-file writeback queue.
// The master presents a destination/result pair; the slave signals space.
interface rf_writeback_queue_if #(
    parameter int AW = 5,
    parameter int DW = 32
);
    logic          wb_valid;
    logic          wb_ready;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;

    modport master (
        output wb_valid,
        output wb_addr,
        output wb_data,
        input  wb_ready
    );

    modport slave (
        input  wb_valid,
        input  wb_addr,
        input  wb_data,
        output wb_ready
    );
endinterface

// File: rtl/rf_writeback_queue.sv
// In-order writeback queue draining one entry per cycle onto the register
// file write port, with youngest-entry forwarding for both read ports.
module rf_writeback_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    rf_writeback_queue_if.slave      wb,
    input  logic                     rf_stall,
    output logic                     WE3,
    output logic [AW-1:0]            A3,
    output logic [DW-1:0]            WD3,
    input  logic [AW-1:0]            A1,
    input  logic [AW-1:0]            A2,
    output logic                     fwd1_hit,
    output logic [DW-1:0]            fwd1_data,
    output logic                     fwd2_hit,
    output logic [DW-1:0]            fwd2_data,
    output logic [$clog2(DEPTH):0]   pending
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] addr_q [DEPTH];
    logic [AW-1:0] addr_d [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [DW-1:0] data_d [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic ready;
    logic accept;
    logic push;
    logic pop;
    logic nonempty;

    always_comb begin
        nonempty = (count_q != '0);
        ready    = !rst && (count_q < CW'(DEPTH));
        accept   = wb.wb_valid && ready;
        // x0 requests complete the handshake but never occupy a slot
        push     = accept && (wb.wb_addr != '0);
        pop      = nonempty && !rf_stall;

        head_d  = head_q + PW'(pop);
        tail_d  = tail_q + PW'(push);
        count_d = count_q + CW'(push) - CW'(pop);

        addr_d = addr_q;
        data_d = data_q;
        if (push) begin
            addr_d[tail_q] = wb.wb_addr;
            data_d[tail_q] = wb.wb_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage needs no reset: only slots covered by count are observed.
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
    end

    always_comb begin
        wb.wb_ready = ready;
        WE3         = !rst && pop;
        A3          = '0;
        WD3         = '0;
        if (!rst && nonempty) begin
            A3  = addr_q[head_q];
            WD3 = data_q[head_q];
        end
        pending = rst ? '0 : count_q;
    end

    // Walk oldest to youngest so the last match wins.
    always_comb begin
        logic [PW-1:0] idx;
        idx       = '0;
        fwd1_hit  = 1'b0;
        fwd1_data = '0;
        fwd2_hit  = 1'b0;
        fwd2_data = '0;
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                idx = head_q + PW'(i);
                if (CW'(i) < count_q) begin
                    if ((A1 != '0) && (addr_q[idx] == A1)) begin
                        fwd1_hit  = 1'b1;
                        fwd1_data = data_q[idx];
                    end
                    if ((A2 != '0) && (addr_q[idx] == A2)) begin
                        fwd2_hit  = 1'b1;
                        fwd2_data = data_q[idx];
                    end
                end
            end
        end
    end

    a_count_bound : assert property (@(posedge clk) disable iff (rst)
        count_q <= CW'(DEPTH));

    a_no_push_when_full : assert property (@(posedge clk) disable iff (rst)
        (count_q == CW'(DEPTH)) |-> !push);

endmodule

// File: tb/tb_rf_writeback_queue.sv
// Directed bench for rf_writeback_queue: vector table plus hand-written
// wrap-around and asynchronous-reset sequences.
module tb_rf_writeback_queue;
    logic        clk = 1'b0;
    logic        rst;
    logic        rf_stall;
    logic        WE3;
    logic [4:0]  A3;
    logic [31:0] WD3;
    logic [4:0]  A1, A2;
    logic        fwd1_hit, fwd2_hit;
    logic [31:0] fwd1_data, fwd2_data;
    logic [2:0]  pending;

    int unsigned passed = 0;
    int unsigned total  = 0;

    rf_writeback_queue_if #(.AW(5), .DW(32)) wbif ();

    rf_writeback_queue #(.DEPTH(4), .AW(5), .DW(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .wb        (wbif),
        .rf_stall  (rf_stall),
        .WE3       (WE3),
        .A3        (A3),
        .WD3       (WD3),
        .A1        (A1),
        .A2        (A2),
        .fwd1_hit  (fwd1_hit),
        .fwd1_data (fwd1_data),
        .fwd2_hit  (fwd2_hit),
        .fwd2_data (fwd2_data),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        stall;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic        ready;
        logic        we;
        logic [4:0]  a3;
        logic [31:0] wd;
        logic        h1;
        logic [31:0] d1;
        logic        h2;
        logic [31:0] d2;
        logic [2:0]  pend;
    } vec_t;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    vec_t vec [20];
    ent_t sb [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else
            passed++;
    endtask

    task automatic drive(input logic v, input logic [4:0] a, input logic [31:0] d,
                         input logic s, input logic [4:0] r1, input logic [4:0] r2);
        wbif.wb_valid = v;
        wbif.wb_addr  = a;
        wbif.wb_data  = d;
        rf_stall      = s;
        A1            = r1;
        A2            = r2;
    endtask

    initial begin
        int unsigned sent;
        int unsigned writes;
        logic        exp_ready;
        logic        exp_we;
        ent_t        e;

        //          valid addr data          stall a1 a2  rdy we a3 wd            h1 d1            h2 d2            pend
        vec[0]  = '{0, 5'd0, 32'h0,          0,  5, 0,  1,  0, 0, 32'h0,          0, 32'h0,          0, 32'h0,          0};
        vec[1]  = '{1, 5'd5, 32'h5,          0,  5, 0,  1,  0, 0, 32'h0,          0, 32'h0,          0, 32'h0,          0};
        vec[2]  = '{0, 5'd0, 32'h0,          0,  5, 0,  1,  1, 5, 32'h5,          1, 32'h5,          0, 32'h0,          1};
        vec[3]  = '{0, 5'd0, 32'h0,          0,  5, 0,  1,  0, 0, 32'h0,          0, 32'h0,          0, 32'h0,          0};
        vec[4]  = '{1, 5'd3, 32'h11,         1,  3, 0,  1,  0, 0, 32'h0,          0, 32'h0,          0, 32'h0,          0};
        vec[5]  = '{1, 5'd7, 32'h22,         1,  3, 0,  1,  0, 3, 32'h11,         1, 32'h11,         0, 32'h0,          1};
        vec[6]  = '{1, 5'd3, 32'h33,         1,  3, 7,  1,  0, 3, 32'h11,         1, 32'h11,         1, 32'h22,         2};
        vec[7]  = '{1, 5'd9, 32'h44,         1,  3, 7,  1,  0, 3, 32'h11,         1, 32'h33,         1, 32'h22,         3};
        vec[8]  = '{1, 5'd12, 32'h55,        1,  3, 9,  0,  0, 3, 32'h11,         1, 32'h33,         1, 32'h44,         4};
        vec[9]  = '{0, 5'd0, 32'h0,          0,  3, 9,  0,  1, 3, 32'h11,         1, 32'h33,         1, 32'h44,         4};
        vec[10] = '{0, 5'd0, 32'h0,          0,  3, 12, 1,  1, 7, 32'h22,         1, 32'h33,         0, 32'h0,          3};
        vec[11] = '{0, 5'd0, 32'h0,          0,  3, 0,  1,  1, 3, 32'h33,         1, 32'h33,         0, 32'h0,          2};
        vec[12] = '{0, 5'd0, 32'h0,          0,  3, 9,  1,  1, 9, 32'h44,         0, 32'h0,          1, 32'h44,         1};
        vec[13] = '{0, 5'd0, 32'h0,          0,  3, 9,  1,  0, 0, 32'h0,          0, 32'h0,          0, 32'h0,          0};
        vec[14] = '{1, 5'd0, 32'hDEADBEEF,   0,  0, 0,  1,  0, 0, 32'h0,          0, 32'h0,          0, 32'h0,          0};
        vec[15] = '{0, 5'd0, 32'h0,          0,  0, 0,  1,  0, 0, 32'h0,          0, 32'h0,          0, 32'h0,          0};
        vec[16] = '{1, 5'd6, 32'h01,         1,  0, 6,  1,  0, 0, 32'h0,          0, 32'h0,          0, 32'h0,          0};
        vec[17] = '{1, 5'd6, 32'h02,         0,  0, 6,  1,  1, 6, 32'h01,         0, 32'h0,          1, 32'h01,         1};
        vec[18] = '{0, 5'd0, 32'h0,          0,  0, 6,  1,  1, 6, 32'h02,         0, 32'h0,          1, 32'h02,         1};
        vec[19] = '{0, 5'd0, 32'h0,          0,  0, 6,  1,  0, 0, 32'h0,          0, 32'h0,          0, 32'h0,          0};

        // Reset state, with a request presented to confirm it is refused
        rst = 1'b1;
        drive(1, 5'd5, 32'h5, 0, 5'd5, 5'd5);
        #2;
        chk("rst.ready",   wbif.wb_ready, 0);
        chk("rst.we",      WE3, 0);
        chk("rst.a3",      A3, 0);
        chk("rst.wd3",     WD3, 0);
        chk("rst.hits",    {fwd1_hit, fwd2_hit}, 0);
        chk("rst.fdata",   {fwd1_data, fwd2_data}, 0);
        chk("rst.pending", pending, 0);
        @(negedge clk);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            drive(vec[i].valid, vec[i].addr, vec[i].data, vec[i].stall, vec[i].a1, vec[i].a2);
            #2;
            chk($sformatf("v%0d.ready", i), wbif.wb_ready, vec[i].ready);
            chk($sformatf("v%0d.we", i),    WE3,           vec[i].we);
            chk($sformatf("v%0d.a3", i),    A3,            vec[i].a3);
            chk($sformatf("v%0d.wd3", i),   WD3,           vec[i].wd);
            chk($sformatf("v%0d.h1", i),    fwd1_hit,      vec[i].h1);
            chk($sformatf("v%0d.d1", i),    fwd1_data,     vec[i].d1);
            chk($sformatf("v%0d.h2", i),    fwd2_hit,      vec[i].h2);
            chk($sformatf("v%0d.d2", i),    fwd2_data,     vec[i].d2);
            chk($sformatf("v%0d.pend", i),  pending,       vec[i].pend);
        end

        // Wrap-around: 12 requests with wb_valid held high, filling to full first
        sent   = 0;
        writes = 0;
        for (int cyc = 0; cyc < 100 && !(sent == 12 && sb.size() == 0); cyc++) begin
            @(negedge clk);
            drive(sent < 12, 5'((sent % 7) + 1), 32'h100 + sent, cyc < 6, 0, 0);
            #2;
            exp_ready = (sb.size() < 4);
            exp_we    = (sb.size() > 0) && !rf_stall;
            chk("wrap.ready",   wbif.wb_ready, exp_ready);
            chk("wrap.pending", pending, sb.size());
            chk("wrap.we",      WE3, exp_we);
            if (exp_we) begin
                e = sb.pop_front();
                chk("wrap.a3",  A3, e.a);
                chk("wrap.wd3", WD3, e.d);
                writes++;
            end
            if (wbif.wb_valid && exp_ready) begin
                sb.push_back('{a: wbif.wb_addr, d: wbif.wb_data});
                sent++;
            end
        end
        chk("wrap.sent",   sent, 12);
        chk("wrap.writes", writes, 12);
        chk("wrap.drain",  sb.size(), 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        #2;
        chk("wrap.idle_pending", pending, 0);
        chk("wrap.idle_we",      WE3, 0);

        // Asynchronous reset mid-cycle with 3 entries pending
        @(negedge clk); drive(1, 5'd4,  32'hA4, 1, 0, 0);
        @(negedge clk); drive(1, 5'd8,  32'hA8, 1, 0, 0);
        @(negedge clk); drive(1, 5'd10, 32'hAA, 1, 0, 0);
        @(negedge clk); drive(0, 0, 0, 0, 5'd4, 5'd10);
        #2;
        chk("arst.pre_we",      WE3, 1);
        chk("arst.pre_pending", pending, 3);
        chk("arst.pre_h1",      {fwd1_hit, fwd1_data}, {1'b1, 32'hA4});
        chk("arst.pre_h2",      {fwd2_hit, fwd2_data}, {1'b1, 32'hAA});
        #1 rst = 1'b1;
        #1;
        chk("arst.we",      WE3, 0);
        chk("arst.pending", pending, 0);
        chk("arst.hits",    {fwd1_hit, fwd2_hit}, 0);
        chk("arst.ready",   wbif.wb_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #2;
            chk("arst.post_we",      WE3, 0);
            chk("arst.post_pending", pending, 0);
            chk("arst.post_hit",     fwd1_hit, 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
